// File: rtl/data_v.sv
// 8-bit multicycle MIPS-subset datapath with register file, IR, MDR, A/B/ALUOut.
// Latency: state loads on the edge after controls are applied; no flow control, the controller sequences every cycle.
module data_v #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] memdata,
    input  logic             alusrca,
    input  logic             memtoreg,
    input  logic             regdst,
    input  logic             iord,
    input  logic             pcen,
    input  logic             regwrite,
    input  logic [1:0]       pcsrc,
    input  logic [1:0]       alusrcb,
    input  logic [3:0]       irwrite,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] read1,
    output logic [WIDTH-1:0] read2,
    output logic [WIDTH-1:0] RgDst,
    output logic             zero,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata
);

    localparam int NREG = 2 ** REGBITS;

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [WIDTH-1:0]   mdr_q, a_q, a_d, b_q, b_d, aluout_q;
    logic [WIDTH-1:0]   rf_q [NREG];

    logic [REGBITS-1:0] rs, rt, wa;
    logic [WIDTH-1:0]   wd, sh_imm, srca, srcb, bb, sum, alu_res, nextpc;
    logic               unused_bits;

    assign rs     = ir_q[21 +: REGBITS];
    assign rt     = ir_q[16 +: REGBITS];
    assign wa     = regdst ? ir_q[11 +: REGBITS] : rt;
    assign wd     = memtoreg ? mdr_q : aluout_q;
    assign sh_imm = {ir_q[WIDTH-3:0], 2'b00};

    assign srca = alusrca ? a_q : pc_q;

    always_comb begin
        srcb = b_q;
        case (alusrcb)
            2'd0: srcb = b_q;
            2'd1: srcb = WIDTH'(1);
            2'd2: srcb = ir_q[WIDTH-1:0];
            2'd3: srcb = sh_imm;
            default: srcb = b_q;
        endcase
    end

    // Inverted B plus carry-in gives subtraction; slt takes the sign of the difference.
    assign bb  = alucontrol[2] ? ~srcb : srcb;
    assign sum = srca + bb + WIDTH'(alucontrol[2]);

    always_comb begin
        alu_res = '0;
        case (alucontrol[1:0])
            2'b00: alu_res = srca & bb;
            2'b01: alu_res = srca | bb;
            2'b10: alu_res = sum;
            2'b11: alu_res = WIDTH'(sum[WIDTH-1]);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        nextpc = '0;
        case (pcsrc)
            2'b00: nextpc = alu_res;
            2'b01: nextpc = aluout_q;
            2'b10: nextpc = sh_imm;
            default: nextpc = '0;
        endcase
    end

    always_comb begin
        pc_d = pcen ? nextpc : pc_q;
        ir_d = ir_q;
        for (int i = 0; i < 4; i++) begin
            if (irwrite[i]) ir_d[8*i +: 8] = memdata[7:0];
        end
        a_d = rf_q[rs];
        b_d = rf_q[rt];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= memdata;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= alu_res;
        end
    end

    // r0 is never written, so it reads as zero without a read-side mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (regwrite && (wa != '0)) begin
            rf_q[wa] <= wd;
        end
    end

    assign read1     = rf_q[a1[REGBITS-1:0]];
    assign read2     = rf_q[b1[REGBITS-1:0]];
    assign RgDst     = {{(WIDTH-REGBITS){1'b0}}, wa};
    assign zero      = (alu_res == '0);
    assign instr     = ir_q;
    assign adr       = iord ? aluout_q : pc_q;
    assign writedata = b_q;

    assign unused_bits = ^{a1[WIDTH-1:REGBITS], b1[WIDTH-1:REGBITS]};

endmodule

// File: tb/tb_data_v.sv
// Directed bench for the data_v multicycle datapath.
module tb_data_v;

    logic        clk, reset;
    logic [7:0]  a1, b1, memdata;
    logic        alusrca, memtoreg, regdst, iord, pcen, regwrite;
    logic [1:0]  pcsrc, alusrcb;
    logic [3:0]  irwrite;
    logic [2:0]  alucontrol;
    logic [7:0]  read1, read2, RgDst, adr, writedata;
    logic        zero;
    logic [31:0] instr;

    int n_cmp = 0;
    int n_err = 0;

    data_v dut (
        .clk(clk), .reset(reset), .a1(a1), .b1(b1), .memdata(memdata),
        .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
        .pcen(pcen), .regwrite(regwrite), .pcsrc(pcsrc), .alusrcb(alusrcb),
        .irwrite(irwrite), .alucontrol(alucontrol),
        .read1(read1), .read2(read2), .RgDst(RgDst), .zero(zero),
        .instr(instr), .adr(adr), .writedata(writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; a1 = 8'h00; b1 = 8'h00; memdata = 8'h00;
        alusrca = 1'b0; memtoreg = 1'b0; regdst = 1'b0; iord = 1'b0;
        pcen = 1'b0; regwrite = 1'b0; pcsrc = 2'b00; alusrcb = 2'd1;
        irwrite = 4'b0000; alucontrol = 3'b010;
        #3;
        n_cmp++; if (adr !== 8'h00) begin n_err++; $display("FAIL reset_adr: got %h want 00", adr); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
        n_cmp++; if (writedata !== 8'h00) begin n_err++; $display("FAIL reset_wdata: got %h want 00", writedata); end
        n_cmp++; if (read1 !== 8'h00) begin n_err++; $display("FAIL reset_read1: got %h want 00", read1); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_cmp++; if (adr !== 8'h00) begin n_err++; $display("FAIL release_pc: got %h want 00", adr); end
        iord = 1'b1; #1;
        n_cmp++; if (adr !== 8'h01) begin n_err++; $display("FAIL release_aluout: got %h want 01", adr); end
        iord = 1'b0;
    endtask

    task automatic test_ir_load();
        logic [7:0] bytes [4];
        bytes[0] = 8'h20; bytes[1] = 8'h20; bytes[2] = 8'h85; bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            memdata = bytes[i];
            irwrite = 4'b0001 << i;
            tick();
            if (i == 0) begin
                n_cmp++; if (instr !== 32'h00000020) begin n_err++; $display("FAIL ir_byte0: got %h want 00000020", instr); end
            end
        end
        irwrite = 4'b0000;
        n_cmp++; if (instr !== 32'h00852020) begin n_err++; $display("FAIL ir_full: got %h want 00852020", instr); end
        regdst = 1'b1; #1;
        n_cmp++; if (RgDst !== 8'h04) begin n_err++; $display("FAIL rgdst_rd: got %h want 04", RgDst); end
        regdst = 1'b0; #1;
        n_cmp++; if (RgDst !== 8'h05) begin n_err++; $display("FAIL rgdst_rt: got %h want 05", RgDst); end
    endtask

    task automatic test_srcb();
        alusrca = 1'b0; alucontrol = 3'b010; alusrcb = 2'd3;
        tick();
        iord = 1'b1; #1;
        n_cmp++; if (adr !== 8'h80) begin n_err++; $display("FAIL srcb_shift: got %h want 80", adr); end
        alusrcb = 2'd2; #1;
        n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL srcb_imm_zero: got %b want 0", zero); end
        tick();
        n_cmp++; if (adr !== 8'h20) begin n_err++; $display("FAIL srcb_imm: got %h want 20", adr); end
    endtask

    task automatic test_alu_ops();
        logic [2:0] ops [7];
        logic [7:0] exps [7];
        ops[0] = 3'b110; exps[0] = 8'hFF;
        ops[1] = 3'b111; exps[1] = 8'h01;
        ops[2] = 3'b000; exps[2] = 8'h00;
        ops[3] = 3'b001; exps[3] = 8'h01;
        ops[4] = 3'b100; exps[4] = 8'h00;
        ops[5] = 3'b101; exps[5] = 8'hFE;
        ops[6] = 3'b010; exps[6] = 8'h01;
        iord = 1'b1; alusrca = 1'b0; alusrcb = 2'd1;
        for (int i = 0; i < 7; i++) begin
            alucontrol = ops[i]; #1;
            n_cmp++; if (zero !== (exps[i] == 8'h00)) begin n_err++; $display("FAIL alu_zero op=%b: got %b want %b", ops[i], zero, exps[i] == 8'h00); end
            tick();
            n_cmp++; if (adr !== exps[i]) begin n_err++; $display("FAIL alu_res op=%b: got %h want %h", ops[i], adr, exps[i]); end
        end
        alusrcb = 2'd0; alucontrol = 3'b010; #1;
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL alu_add_zero: got %b want 1", zero); end
        iord = 1'b0; #1;
        n_cmp++; if (adr !== 8'h00) begin n_err++; $display("FAIL pc_hold: got %h want 00", adr); end
    endtask

    task automatic test_regfile();
        alusrcb = 2'd2; alusrca = 1'b0; alucontrol = 3'b010;
        tick();
        regdst = 1'b1; memtoreg = 1'b0; regwrite = 1'b1; a1 = 8'h33; b1 = 8'h84; #1;
        n_cmp++; if (read2 !== 8'h00) begin n_err++; $display("FAIL no_write_through: got %h want 00", read2); end
        tick();
        regwrite = 1'b0; #1;
        n_cmp++; if (read2 !== 8'h20) begin n_err++; $display("FAIL rf_write_r4: got %h want 20", read2); end
        n_cmp++; if (read1 !== 8'h00) begin n_err++; $display("FAIL rf_read_r3: got %h want 00", read1); end
        tick();
        alusrca = 1'b1; alusrcb = 2'd1;
        tick();
        iord = 1'b1; #1;
        n_cmp++; if (adr !== 8'h21) begin n_err++; $display("FAIL a_reg_add: got %h want 21", adr); end
        iord = 1'b0;
        memdata = 8'h5A;
        tick();
        regdst = 1'b0; memtoreg = 1'b1; regwrite = 1'b1;
        tick();
        regwrite = 1'b0; b1 = 8'h05; #1;
        n_cmp++; if (read2 !== 8'h5A) begin n_err++; $display("FAIL rf_mdr_r5: got %h want 5a", read2); end
        tick();
        n_cmp++; if (writedata !== 8'h5A) begin n_err++; $display("FAIL b_writedata: got %h want 5a", writedata); end
        memdata = 8'h00; irwrite = 4'b0011;
        tick();
        irwrite = 4'b0000; #1;
        n_cmp++; if (instr !== 32'h00850000) begin n_err++; $display("FAIL ir_multi: got %h want 00850000", instr); end
        regdst = 1'b1; memtoreg = 1'b0; #1;
        n_cmp++; if (RgDst !== 8'h00) begin n_err++; $display("FAIL rgdst_r0: got %h want 00", RgDst); end
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0; a1 = 8'h00; #1;
        n_cmp++; if (read1 !== 8'h00) begin n_err++; $display("FAIL r0_ignored: got %h want 00", read1); end
    endtask

    task automatic test_pc();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03; exp_pc[3] = 8'h00;
        memdata = 8'h07; irwrite = 4'b0001; pcen = 1'b0;
        tick();
        irwrite = 4'b0000;
        iord = 1'b0; alusrca = 1'b0; alusrcb = 2'd1; alucontrol = 3'b010;
        pcsrc = 2'b00; pcen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (adr !== exp_pc[i]) begin n_err++; $display("FAIL pc_inc%0d: got %h want %h", i, adr, exp_pc[i]); end
        end
        pcsrc = 2'b01;
        tick();
        n_cmp++; if (adr !== 8'h03) begin n_err++; $display("FAIL pc_aluout_a: got %h want 03", adr); end
        tick();
        n_cmp++; if (adr !== 8'h04) begin n_err++; $display("FAIL pc_aluout_b: got %h want 04", adr); end
        pcsrc = 2'b11;
        tick();
        n_cmp++; if (adr !== 8'h00) begin n_err++; $display("FAIL pc_zero: got %h want 00", adr); end
        pcsrc = 2'b10;
        tick();
        n_cmp++; if (adr !== 8'h1C) begin n_err++; $display("FAIL pc_jump: got %h want 1c", adr); end
        pcen = 1'b0; iord = 1'b1; #1;
        n_cmp++; if (adr !== 8'h01) begin n_err++; $display("FAIL adr_iord: got %h want 01", adr); end
        iord = 1'b0; b1 = 8'h04;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (adr !== 8'h00) begin n_err++; $display("FAIL async_pc: got %h want 00", adr); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL async_instr: got %h want 0", instr); end
        n_cmp++; if (read2 !== 8'h00) begin n_err++; $display("FAIL async_rf: got %h want 00", read2); end
        @(negedge clk);
        reset = 1'b1; pcsrc = 2'b00; pcen = 1'b1;
        tick();
        pcen = 1'b0;
        n_cmp++; if (adr !== 8'h01) begin n_err++; $display("FAIL post_reset_pc: got %h want 01", adr); end
    endtask

    initial begin
        test_reset();
        test_ir_load();
        test_srcb();
        test_alu_ops();
        test_regfile();
        test_pc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
